// File: rtl/jk_latch_driver.sv
// jk_latch_driver: sequences setup / Enable pulse / hold on a bank of gated JK latches.
// Latency: accept-to-Done = SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles; a clear takes PULSE_CYC+1.
// Backpressure: Req_ready is high only in IDLE/FIN. Optional macro JK_LATCH_DRIVER_SKIP_EN skips no-change requests.
module jk_latch_driver #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req_valid,
  output logic             Req_ready,
  input  logic [WIDTH-1:0] Req_data,
  input  logic             Req_clear,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             Enable,
  output logic             Clear,
  output logic [WIDTH-1:0] Shadow,
  output logic             Done
);

  // Phase counters load (length-1) and advance the FSM when they reach zero.
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CLR   = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] t_q;
  logic [WIDTH-1:0] j_q;
  logic [WIDTH-1:0] k_q;
  logic             en_q;
  logic             clr_n_q;
  logic [WIDTH-1:0] shadow_q;
  logic             ready_q;
  logic             done_q;

  // Excitation derived from the incoming target against the current shadow.
  // J and K are disjoint by construction, so J=K=1 can never reach the bank.
  logic             accept_d;
  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;
  logic             skip_d;

  // Acceptance and excitation for a request presented this cycle.
  always_comb begin
    accept_d = Req_valid & ready_q;
    j_d      = Req_data & ~shadow_q;
    k_d      = ~Req_data & shadow_q;
`ifdef JK_LATCH_DRIVER_SKIP_EN
    skip_d   = ~Req_clear & (Req_data == shadow_q);
`else
    skip_d   = 1'b0;
`endif
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      t_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      en_q     <= 1'b0;
      clr_n_q  <= 1'b0;
      shadow_q <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // FIN behaves like IDLE for acceptance so back-to-back requests
        // lose no cycle.
        ST_IDLE, ST_FIN: begin
          j_q     <= '0;
          k_q     <= '0;
          en_q    <= 1'b0;
          clr_n_q <= 1'b1;
          if (accept_d) begin
            ready_q <= 1'b0;
            if (Req_clear) begin
              state_q <= ST_CLR;
              clr_n_q <= 1'b0;
              cnt_q   <= PULSE_LD;
            end else if (skip_d) begin
              // Target already matches the bank: complete without a pulse.
              state_q <= ST_FIN;
              t_q     <= Req_data;
              done_q  <= 1'b1;
              ready_q <= 1'b1;
            end else begin
              state_q <= ST_SETUP;
              t_q     <= Req_data;
              j_q     <= j_d;
              k_q     <= k_d;
              cnt_q   <= SETUP_LD;
            end
          end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end

        ST_SETUP: begin
          if (cnt_q == '0) begin
            state_q <= ST_PULSE;
            en_q    <= 1'b1;
            cnt_q   <= PULSE_LD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_PULSE: begin
          if (cnt_q == '0) begin
            state_q <= ST_HOLD;
            en_q    <= 1'b0;
            cnt_q   <= HOLD_LD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_HOLD: begin
          if (cnt_q == '0) begin
            // Bank now holds the target; drop excitation and record it.
            state_q  <= ST_FIN;
            j_q      <= '0;
            k_q      <= '0;
            shadow_q <= t_q;
            done_q   <= 1'b1;
            ready_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_CLR: begin
          if (cnt_q == '0) begin
            state_q  <= ST_FIN;
            clr_n_q  <= 1'b1;
            shadow_q <= '0;
            done_q   <= 1'b1;
            ready_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          j_q     <= '0;
          k_q     <= '0;
          en_q    <= 1'b0;
          clr_n_q <= 1'b1;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign Req_ready = ready_q;
  assign J         = j_q;
  assign K         = k_q;
  assign Enable    = en_q;
  assign Clear     = clr_n_q;
  assign Shadow    = shadow_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_jk_latch_driver.sv
// Directed bench for jk_latch_driver with default timing parameters.
// Cycle k means the outputs observed 1 time unit after the k-th edge following acceptance.
// J&K==0 and never (Enable & ~Clear) are checked after every edge.
module tb_jk_latch_driver;

  logic       Clk;
  logic       Reset;
  logic       Req_valid;
  logic       Req_ready;
  logic [7:0] Req_data;
  logic       Req_clear;
  logic [7:0] J;
  logic [7:0] K;
  logic       Enable;
  logic       Clear;
  logic [7:0] Shadow;
  logic       Done;

  int tests;
  int failed;

  jk_latch_driver #(
    .WIDTH(8), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .Req_valid(Req_valid), .Req_ready(Req_ready),
    .Req_data(Req_data), .Req_clear(Req_clear),
    .J(J), .K(K), .Enable(Enable), .Clear(Clear),
    .Shadow(Shadow), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one edge, then check the per-cycle invariants.
  task automatic tick();
    @(posedge Clk);
    #1;
    chk8("jk_disjoint", J & K, 8'h00);
    chk1("en_clr_excl", Enable & ~Clear, 1'b0);
  endtask

  // Present a request for exactly one edge; afterwards the bench is at cycle 1.
  task automatic issue(input logic [7:0] data, input logic clr);
    Req_valid = 1'b1;
    Req_data  = data;
    Req_clear = clr;
    tick();
    Req_valid = 1'b0;
    Req_data  = ~data;   // must be ignored after acceptance
    Req_clear = ~clr;
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    Reset     = 1'b1;
    Req_valid = 1'b0;
    Req_data  = 8'h00;
    Req_clear = 1'b0;

    // Reset held for 3 cycles.
    tick(); tick(); tick();
    chk1("rst_clear",  Clear, 1'b0);
    chk1("rst_ready",  Req_ready, 1'b0);
    chk8("rst_j",      J, 8'h00);
    chk8("rst_k",      K, 8'h00);
    chk8("rst_shadow", Shadow, 8'h00);
    chk1("rst_enable", Enable, 1'b0);
    chk1("rst_done",   Done, 1'b0);

    Reset = 1'b0;
    tick();
    chk1("post_rst_clear", Clear, 1'b1);
    chk1("post_rst_ready", Req_ready, 1'b1);
    chk1("post_rst_en",    Enable, 1'b0);
    chk1("post_rst_done",  Done, 1'b0);

    // 0x00 -> 0xA5
    issue(8'hA5, 1'b0);
    chk8("a5_c1_j", J, 8'hA5);
    chk8("a5_c1_k", K, 8'h00);
    chk1("a5_c1_en", Enable, 1'b0);
    chk1("a5_c1_rdy", Req_ready, 1'b0);
    tick();
    chk1("a5_c2_en", Enable, 1'b1);
    tick();
    chk1("a5_c3_en", Enable, 1'b1);
    chk8("a5_c3_j", J, 8'hA5);
    tick();
    chk1("a5_c4_en", Enable, 1'b0);
    chk8("a5_c4_j", J, 8'hA5);
    chk1("a5_c4_done", Done, 1'b0);
    tick();
    chk1("a5_c5_done", Done, 1'b1);
    chk8("a5_c5_shadow", Shadow, 8'hA5);
    chk8("a5_c5_j", J, 8'h00);
    chk1("a5_c5_rdy", Req_ready, 1'b1);
    tick();
    chk1("a5_idle_done", Done, 1'b0);
    chk1("a5_idle_rdy", Req_ready, 1'b1);

    // 0xA5 -> 0x3C
    issue(8'h3C, 1'b0);
    chk8("3c_c1_j", J, 8'h18);
    chk8("3c_c1_k", K, 8'h81);
    tick();
    chk1("3c_c2_en", Enable, 1'b1);
    chk8("3c_c2_k", K, 8'h81);
    tick(); tick(); tick();
    chk1("3c_c5_done", Done, 1'b1);
    chk8("3c_c5_shadow", Shadow, 8'h3C);

    // Back-to-back 0x3C -> 0xFF, accepted in FIN.
    issue(8'hFF, 1'b0);
    chk1("b2b_c1_done", Done, 1'b0);
    chk8("b2b_c1_j", J, 8'hC3);
    chk8("b2b_c1_k", K, 8'h00);
    tick(); tick(); tick(); tick();
    chk1("b2b_c5_done", Done, 1'b1);
    chk8("b2b_c5_shadow", Shadow, 8'hFF);
    tick();

    // Bank clear from 0xFF.
    issue(8'h5A, 1'b1);
    chk1("clr_c1_clear", Clear, 1'b0);
    chk1("clr_c1_en", Enable, 1'b0);
    chk8("clr_c1_j", J, 8'h00);
    chk8("clr_c1_shadow", Shadow, 8'hFF);
    tick();
    chk1("clr_c2_clear", Clear, 1'b0);
    chk1("clr_c2_en", Enable, 1'b0);
    chk1("clr_c2_done", Done, 1'b0);
    tick();
    chk1("clr_c3_done", Done, 1'b1);
    chk1("clr_c3_clear", Clear, 1'b1);
    chk8("clr_c3_shadow", Shadow, 8'h00);
    tick();

    // Load 0x3C, then request 0x3C again.
    issue(8'h3C, 1'b0);
    chk8("ld3c_c1_j", J, 8'h3C);
    tick(); tick(); tick(); tick();
    chk8("ld3c_c5_shadow", Shadow, 8'h3C);
    tick();
    issue(8'h3C, 1'b0);
`ifdef JK_LATCH_DRIVER_SKIP_EN
    chk1("same_c1_done", Done, 1'b1);
    chk1("same_c1_en", Enable, 1'b0);
    chk8("same_c1_shadow", Shadow, 8'h3C);
    tick();
    chk1("same_c2_en", Enable, 1'b0);
    chk1("same_c2_done", Done, 1'b0);
`else
    chk8("same_c1_j", J, 8'h00);
    chk8("same_c1_k", K, 8'h00);
    chk1("same_c1_done", Done, 1'b0);
    tick();
    chk8("same_c2_j", J, 8'h00);
    chk8("same_c2_k", K, 8'h00);
    tick(); tick();
    chk8("same_c4_j", J, 8'h00);
    chk1("same_c4_done", Done, 1'b0);
    tick();
    chk1("same_c5_done", Done, 1'b1);
    chk8("same_c5_shadow", Shadow, 8'h3C);
    tick();
`endif

    // Reset during PULSE of a 0xFF request.
    issue(8'hFF, 1'b0);
    chk8("abort_c1_j", J, 8'hC3);
    tick();
    chk1("abort_c2_en", Enable, 1'b1);
    Reset = 1'b1;
    tick();
    chk1("abort_en", Enable, 1'b0);
    chk8("abort_j", J, 8'h00);
    chk8("abort_k", K, 8'h00);
    chk1("abort_clear", Clear, 1'b0);
    chk8("abort_shadow", Shadow, 8'h00);
    chk1("abort_done", Done, 1'b0);
    chk1("abort_rdy", Req_ready, 1'b0);
    Reset = 1'b0;
    tick();
    chk1("abort_post_clear", Clear, 1'b1);
    chk1("abort_post_rdy", Req_ready, 1'b1);

    // Fresh request after the abort: 0x00 -> 0x55.
    issue(8'h55, 1'b0);
    chk8("fresh_c1_j", J, 8'h55);
    chk8("fresh_c1_k", K, 8'h00);
    tick();
    chk1("fresh_c2_en", Enable, 1'b1);
    tick(); tick(); tick();
    chk1("fresh_c5_done", Done, 1'b1);
    chk8("fresh_c5_shadow", Shadow, 8'h55);
    tick();
    chk1("fresh_idle_done", Done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
